// File: rtl/bfly_r2_pipe_if.sv
// Stream bundle for bfly_r2_pipe: operand beat in, result beat out, overflow flag/clear.
// master = upstream/downstream environment, slave = butterfly engine.
interface bfly_r2_pipe_if #(
  parameter int DATA_W = 32,
  parameter int TW_W   = 16,
  parameter int TAG_W  = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] a_re;
  logic signed [DATA_W-1:0] a_im;
  logic signed [DATA_W-1:0] b_re;
  logic signed [DATA_W-1:0] b_im;
  logic signed [TW_W-1:0]   w_re;
  logic signed [TW_W-1:0]   w_im;
  logic [TAG_W-1:0]         tag_in;
  logic                     scale;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] x_re;
  logic signed [DATA_W-1:0] x_im;
  logic signed [DATA_W-1:0] y_re;
  logic signed [DATA_W-1:0] y_im;
  logic [TAG_W-1:0]         tag_out;
  logic                     ovf;
  logic                     ovf_clr;

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, w_re, w_im, tag_in, scale, out_ready, ovf_clr,
    input  in_ready, out_valid, x_re, x_im, y_re, y_im, tag_out, ovf
  );

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, w_re, w_im, tag_in, scale, out_ready, ovf_clr,
    output in_ready, out_valid, x_re, x_im, y_re, y_im, tag_out, ovf
  );
endinterface

// File: rtl/bfly_r2_pipe.sv
// Radix-2 DIT butterfly X=A+W*B, Y=A-W*B; 4-stage pipe, latency 4, global stall (in_ready = !v[3] || out_ready).
// Out-of-range results wrap by default; define BFLY_SAT_EN to saturate them instead.
module bfly_r2_pipe #(
  parameter int DATA_W = 32,
  parameter int TW_W   = 16,
  parameter int TAG_W  = 5
) (
  input  logic          clk,
  input  logic          reset,
  bfly_r2_pipe_if.slave io
);

  localparam int PW = DATA_W + TW_W;
  localparam int SW = DATA_W + TW_W + 1;
  localparam int QW = DATA_W + 2;
  localparam int RW = DATA_W + 3;

  localparam logic signed [SW-1:0] RND   = SW'(1) << (TW_W - 2);
  localparam logic signed [RW-1:0] ONE_R = RW'(1);

  typedef struct packed {
    logic [DATA_W-1:0] a_re;
    logic [DATA_W-1:0] a_im;
    logic [DATA_W-1:0] b_re;
    logic [DATA_W-1:0] b_im;
    logic [TW_W-1:0]   w_re;
    logic [TW_W-1:0]   w_im;
    logic [TAG_W-1:0]  tag;
    logic              scale;
  } s0_t;

  typedef struct packed {
    logic [DATA_W-1:0] a_re;
    logic [DATA_W-1:0] a_im;
    logic [PW-1:0]     rr;
    logic [PW-1:0]     ii;
    logic [PW-1:0]     ri;
    logic [PW-1:0]     ir;
    logic [TAG_W-1:0]  tag;
    logic              scale;
  } s1_t;

  typedef struct packed {
    logic [DATA_W-1:0] a_re;
    logic [DATA_W-1:0] a_im;
    logic [QW-1:0]     p_re;
    logic [QW-1:0]     p_im;
    logic [TAG_W-1:0]  tag;
    logic              scale;
  } s2_t;

  typedef struct packed {
    logic [DATA_W-1:0] x_re;
    logic [DATA_W-1:0] x_im;
    logic [DATA_W-1:0] y_re;
    logic [DATA_W-1:0] y_im;
    logic [TAG_W-1:0]  tag;
    logic              ovf;
  } s3_t;

  logic [3:0] v;
  logic       adv;
  logic       ovf_q;
  logic       ovf_set;
  s0_t        s0, s0_d;
  s1_t        s1, s1_d;
  s2_t        s2, s2_d;
  s3_t        s3, s3_d;

  // Optional halving, then fold to DATA_W bits; MSB of the result is the overflow bit.
  function automatic logic [DATA_W:0] reduce(input logic signed [RW-1:0] val, input logic scl);
    logic signed [RW-1:0] t;
    logic                 of;
    logic [DATA_W-1:0]    r;
    t  = scl ? ((val + ONE_R) >>> 1) : val;
    of = !((&t[RW-1:DATA_W-1]) || !(|t[RW-1:DATA_W-1]));
`ifdef BFLY_SAT_EN
    if (of) r = t[RW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else    r = t[DATA_W-1:0];
`else
    r = t[DATA_W-1:0];
`endif
    return {of, r};
  endfunction

  assign adv     = !v[3] || io.out_ready;
  assign ovf_set = v[3] && io.out_ready && s3.ovf;

  always_comb begin
    s0_d       = '0;
    s0_d.a_re  = io.a_re;
    s0_d.a_im  = io.a_im;
    s0_d.b_re  = io.b_re;
    s0_d.b_im  = io.b_im;
    s0_d.w_re  = io.w_re;
    s0_d.w_im  = io.w_im;
    s0_d.tag   = io.tag_in;
    s0_d.scale = io.scale;
  end

  always_comb begin
    s1_d       = '0;
    s1_d.a_re  = s0.a_re;
    s1_d.a_im  = s0.a_im;
    s1_d.rr    = PW'($signed(s0.b_re)) * PW'($signed(s0.w_re));
    s1_d.ii    = PW'($signed(s0.b_im)) * PW'($signed(s0.w_im));
    s1_d.ri    = PW'($signed(s0.b_re)) * PW'($signed(s0.w_im));
    s1_d.ir    = PW'($signed(s0.b_im)) * PW'($signed(s0.w_re));
    s1_d.tag   = s0.tag;
    s1_d.scale = s0.scale;
  end

  // Round-to-nearest back into data scale: twiddles are Q1.(TW_W-1).
  always_comb begin
    logic signed [SW-1:0] sum_re;
    logic signed [SW-1:0] sum_im;
    sum_re     = $signed({s1.rr[PW-1], s1.rr}) - $signed({s1.ii[PW-1], s1.ii}) + RND;
    sum_im     = $signed({s1.ri[PW-1], s1.ri}) + $signed({s1.ir[PW-1], s1.ir}) + RND;
    s2_d       = '0;
    s2_d.a_re  = s1.a_re;
    s2_d.a_im  = s1.a_im;
    s2_d.p_re  = QW'(sum_re >>> (TW_W - 1));
    s2_d.p_im  = QW'(sum_im >>> (TW_W - 1));
    s2_d.tag   = s1.tag;
    s2_d.scale = s1.scale;
  end

  always_comb begin
    logic signed [RW-1:0] xr, xi, yr, yi;
    logic [DATA_W:0]      rxr, rxi, ryr, ryi;
    xr   = RW'($signed(s2.a_re)) + RW'($signed(s2.p_re));
    xi   = RW'($signed(s2.a_im)) + RW'($signed(s2.p_im));
    yr   = RW'($signed(s2.a_re)) - RW'($signed(s2.p_re));
    yi   = RW'($signed(s2.a_im)) - RW'($signed(s2.p_im));
    rxr  = reduce(xr, s2.scale);
    rxi  = reduce(xi, s2.scale);
    ryr  = reduce(yr, s2.scale);
    ryi  = reduce(yi, s2.scale);
    s3_d      = '0;
    s3_d.x_re = rxr[DATA_W-1:0];
    s3_d.x_im = rxi[DATA_W-1:0];
    s3_d.y_re = ryr[DATA_W-1:0];
    s3_d.y_im = ryi[DATA_W-1:0];
    s3_d.tag  = s2.tag;
    s3_d.ovf  = rxr[DATA_W] | rxi[DATA_W] | ryr[DATA_W] | ryi[DATA_W];
  end

  // Stage data only moves with a valid beat so idle outputs stay put.
  always_ff @(posedge clk) begin
    if (reset) begin
      v     <= '0;
      s0    <= '0;
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (adv) begin
        v <= {v[2:0], io.in_valid};
        if (io.in_valid) s0 <= s0_d;
        if (v[0])        s1 <= s1_d;
        if (v[1])        s2 <= s2_d;
        if (v[2])        s3 <= s3_d;
      end
      ovf_q <= ovf_set || (ovf_q && !io.ovf_clr);
    end
  end

  assign io.in_ready  = adv;
  assign io.out_valid = v[3];
  assign io.x_re      = s3.x_re;
  assign io.x_im      = s3.x_im;
  assign io.y_re      = s3.y_re;
  assign io.y_im      = s3.y_im;
  assign io.tag_out   = s3.tag;
  assign io.ovf       = ovf_q;

endmodule

// File: tb/tb_bfly_r2_pipe.sv
// Bench for bfly_r2_pipe: directed vector table, stall/reset/sticky-flag sequences and random traffic vs an arithmetic model.
module tb_bfly_r2_pipe;
  localparam int DW  = 16;
  localparam int TW  = 16;
  localparam int TGW = 5;
  localparam longint MAXV = 32767;
  localparam longint MINV = -32768;
  localparam longint HALF = 32768;
  localparam longint FULL = 65536;
`ifdef BFLY_SAT_EN
  localparam int OVX = 32767;
`else
  localparam int OVX = -3;
`endif

  typedef struct { int a_re, a_im, b_re, b_im, w_re, w_im, tag; bit scale; } beat_t;
  typedef struct { int x_re, x_im, y_re, y_im, tag; bit ovf; int acc_cyc; } res_t;
  typedef struct { beat_t b; int x_re, x_im, y_re, y_im; bit ovf; } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bfly_r2_pipe_if #(.DATA_W(DW), .TW_W(TW), .TAG_W(TGW)) bi ();
  bfly_r2_pipe #(.DATA_W(DW), .TW_W(TW), .TAG_W(TGW)) dut (.clk(clk), .reset(reset), .io(bi));

  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    n_out = 0;
  int    last_lat = -1;
  int    lo_x_re, lo_x_im, lo_y_re, lo_y_im;
  bit    ovf_m = 1'b0;
  bit    acc;
  res_t  sb[$];
  int    out_tags[$];
  beat_t zb;
  vec_t  tv[5];
  beat_t bp[6];

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  function automatic void red(input longint val, input bit s, output int r, output bit of);
    longint t;
    t  = s ? ((val + longint'(1)) >>> 1) : val;
    of = (t > MAXV) || (t < MINV);
`ifdef BFLY_SAT_EN
    r = of ? ((t > 0) ? int'(MAXV) : int'(MINV)) : int'(t);
`else
    r = int'(((t + HALF) % FULL + FULL) % FULL - HALF);
`endif
  endfunction

  function automatic res_t model(input beat_t b);
    res_t   r;
    longint pr, pim, rnd;
    bit     o0, o1, o2, o3;
    rnd = longint'(1) << (TW - 2);
    pr  = (longint'(b.b_re) * longint'(b.w_re) - longint'(b.b_im) * longint'(b.w_im) + rnd) >>> (TW - 1);
    pim = (longint'(b.b_re) * longint'(b.w_im) + longint'(b.b_im) * longint'(b.w_re) + rnd) >>> (TW - 1);
    red(longint'(b.a_re) + pr,  b.scale, r.x_re, o0);
    red(longint'(b.a_im) + pim, b.scale, r.x_im, o1);
    red(longint'(b.a_re) - pr,  b.scale, r.y_re, o2);
    red(longint'(b.a_im) - pim, b.scale, r.y_im, o3);
    r.ovf     = o0 | o1 | o2 | o3;
    r.tag     = b.tag;
    r.acc_cyc = 0;
    return r;
  endfunction

  function automatic beat_t rnd_beat(input int tag);
    beat_t b;
    b.a_re  = int'($urandom_range(0, 65535)) - 32768;
    b.a_im  = int'($urandom_range(0, 65535)) - 32768;
    b.b_re  = int'($urandom_range(0, 65535)) - 32768;
    b.b_im  = int'($urandom_range(0, 65535)) - 32768;
    b.w_re  = int'($urandom_range(0, 65535)) - 32768;
    b.w_im  = int'($urandom_range(0, 65535)) - 32768;
    b.tag   = tag;
    b.scale = bit'($urandom_range(0, 1));
    return b;
  endfunction

  // One cycle: drive at the falling edge, then sample and score just after it.
  task automatic step(input bit iv, input beat_t b, input bit ordy, input bit clr, output bit accepted);
    bit   cons;
    res_t e;
    @(negedge clk);
    bi.in_valid  = iv;
    bi.a_re      = DW'(b.a_re);
    bi.a_im      = DW'(b.a_im);
    bi.b_re      = DW'(b.b_re);
    bi.b_im      = DW'(b.b_im);
    bi.w_re      = TW'(b.w_re);
    bi.w_im      = TW'(b.w_im);
    bi.tag_in    = TGW'(b.tag);
    bi.scale     = b.scale;
    bi.out_ready = ordy;
    bi.ovf_clr   = clr;
    #1;
    cyc++;
    check("ovf_flag", int'(bi.ovf), int'(ovf_m));
    accepted = iv && (bi.in_ready === 1'b1);
    cons     = (bi.out_valid === 1'b1) && ordy;
    if (bi.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: out_valid=1 with nothing outstanding, required 0");
      end else begin
        e = sb[0];
        check("x_re", int'(bi.x_re), e.x_re);
        check("x_im", int'(bi.x_im), e.x_im);
        check("y_re", int'(bi.y_re), e.y_re);
        check("y_im", int'(bi.y_im), e.y_im);
        check("tag_out", int'(bi.tag_out), e.tag);
      end
    end
    ovf_m = (cons && sb.size() > 0 && sb[0].ovf) || (ovf_m && !clr);
    if (cons && sb.size() > 0) begin
      last_lat = cyc - sb[0].acc_cyc;
      lo_x_re  = int'(bi.x_re);
      lo_x_im  = int'(bi.x_im);
      lo_y_re  = int'(bi.y_re);
      lo_y_im  = int'(bi.y_im);
      out_tags.push_back(int'(bi.tag_out));
      n_out++;
      void'(sb.pop_front());
    end
    if (accepted) begin
      e = model(b);
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bi.in_valid  = 1'b0;
    bi.out_ready = 1'b1;
    bi.ovf_clr   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    out_tags.delete();
    ovf_m = 1'b0;
  endtask

  task automatic drain(input int lim);
    bit a;
    int k;
    k = 0;
    while (sb.size() > 0 && k < lim) begin
      step(1'b0, zb, 1'b1, 1'b0, a);
      k++;
    end
    check("drain_outstanding", sb.size(), 0);
  endtask

  task automatic wait_out(input int n0, input bit ordy);
    bit a;
    int k;
    k = 0;
    while (n_out == n0 && k < 12) begin
      step(1'b0, zb, ordy, 1'b0, a);
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, idx, k;
    zb = '{0, 0, 0, 0, 0, 0, 0, 1'b0};
    bi.in_valid = 1'b0; bi.out_ready = 1'b1; bi.ovf_clr = 1'b0; bi.scale = 1'b0;
    bi.a_re = '0; bi.a_im = '0; bi.b_re = '0; bi.b_im = '0;
    bi.w_re = '0; bi.w_im = '0; bi.tag_in = '0;

    tv[0] = '{'{100, 0, 50, 0, 32767, 0, 3, 1'b0}, 150, 0, 50, 0, 1'b0};
    tv[1] = '{'{100, 0, 50, 0, 32767, 0, 4, 1'b1}, 75, 0, 25, 0, 1'b0};
    tv[2] = '{'{0, 0, 1000, 0, 0, -32768, 17, 1'b0}, 0, -1000, 0, 1000, 1'b0};
    tv[3] = '{'{32767, 0, 32767, 0, 32767, 0, 5, 1'b0}, OVX, 0, 1, 0, 1'b1};
    tv[4] = '{'{32767, 0, 32767, 0, 32767, 0, 6, 1'b1}, 32767, 0, 1, 0, 1'b0};

    do_reset();
    #1;
    check("rst_out_valid", int'(bi.out_valid), 0);
    check("rst_in_ready", int'(bi.in_ready), 1);
    check("rst_ovf", int'(bi.ovf), 0);
    check("rst_tag_out", int'(bi.tag_out), 0);
    check("rst_x_re", int'(bi.x_re), 0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      last_lat = -1;
      n0 = n_out;
      step(1'b1, tv[i].b, 1'b1, 1'b0, acc);
      check($sformatf("vec%0d_accept", i), int'(acc), 1);
      wait_out(n0, 1'b1);
      check($sformatf("vec%0d_latency", i), last_lat, 4);
      check($sformatf("vec%0d_x_re", i), lo_x_re, tv[i].x_re);
      check($sformatf("vec%0d_x_im", i), lo_x_im, tv[i].x_im);
      check($sformatf("vec%0d_y_re", i), lo_y_re, tv[i].y_re);
      check($sformatf("vec%0d_y_im", i), lo_y_im, tv[i].y_im);
      step(1'b0, zb, 1'b1, 1'b0, acc);
      check($sformatf("vec%0d_ovf", i), int'(bi.ovf), int'(tv[i].ovf));
    end

    // Sticky flag: survives clean traffic, clears alone, loses to a coincident set.
    do_reset();
    step(1'b1, tv[3].b, 1'b1, 1'b0, acc);
    drain(20);
    step(1'b0, zb, 1'b1, 1'b0, acc);
    check("sticky_set", int'(bi.ovf), 1);
    for (int i = 0; i < 10; i++) step(1'b1, tv[0].b, 1'b1, 1'b0, acc);
    drain(20);
    check("sticky_after_clean", int'(bi.ovf), 1);
    step(1'b0, zb, 1'b1, 1'b1, acc);
    step(1'b0, zb, 1'b1, 1'b0, acc);
    check("sticky_cleared", int'(bi.ovf), 0);
    step(1'b1, tv[3].b, 1'b0, 1'b0, acc);
    k = 0;
    while (bi.out_valid !== 1'b1 && k < 10) begin
      step(1'b0, zb, 1'b0, 1'b0, acc);
      k++;
    end
    step(1'b0, zb, 1'b1, 1'b1, acc);
    step(1'b0, zb, 1'b1, 1'b0, acc);
    check("set_beats_clear", int'(bi.ovf), 1);

    // Backpressure: four beats fill the pipe, the rest wait for release.
    do_reset();
    for (int i = 0; i < 6; i++) bp[i] = rnd_beat(i);
    idx = 0;
    for (int s = 0; s < 8; s++) begin
      step(1'b1, bp[idx], 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    check("bp_accepted", idx, 4);
    check("bp_in_ready", int'(bi.in_ready), 0);
    check("bp_out_valid", int'(bi.out_valid), 1);
    check("bp_hold_tag", int'(bi.tag_out), 0);
    k = 0;
    while (idx < 6 && k < 20) begin
      step(1'b1, bp[idx], 1'b1, 1'b0, acc);
      if (acc) idx++;
      k++;
    end
    drain(20);
    check("bp_out_count", out_tags.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < out_tags.size()) check($sformatf("bp_order%0d", i), out_tags[i], i);

    // Reset mid-stream: in-flight beats and flag vanish, a fresh beat goes through alone.
    do_reset();
    step(1'b1, tv[3].b, 1'b1, 1'b0, acc);
    drain(20);
    step(1'b0, zb, 1'b1, 1'b0, acc);
    for (int i = 0; i < 3; i++) step(1'b1, rnd_beat(20 + i), 1'b1, 1'b0, acc);
    do_reset();
    #1;
    check("mid_rst_out_valid", int'(bi.out_valid), 0);
    check("mid_rst_ovf", int'(bi.ovf), 0);
    check("mid_rst_in_ready", int'(bi.in_ready), 1);
    check("mid_rst_x_re", int'(bi.x_re), 0);
    check("mid_rst_y_re", int'(bi.y_re), 0);
    check("mid_rst_tag", int'(bi.tag_out), 0);
    n0 = n_out;
    last_lat = -1;
    step(1'b1, tv[2].b, 1'b1, 1'b0, acc);
    wait_out(n0, 1'b1);
    check("mid_rst_latency", last_lat, 4);
    for (int i = 0; i < 6; i++) step(1'b0, zb, 1'b1, 1'b0, acc);
    check("mid_rst_single_out", n_out - n0, 1);

    // Random traffic with random stalls and occasional clears.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 9) < 7), rnd_beat(i % 32),
           bit'($urandom_range(0, 9) < 7), bit'($urandom_range(0, 19) == 0), acc);
    end
    drain(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bfly_r2_pipe.md
# bfly_r2_pipe

Parametrised, pipelined radix-2 DIT butterfly engine with valid/ready flow control, runtime 1/2 scaling and a sticky overflow flag. It computes X = A + W·B and Y = A − W·B on one complex pair per cycle and carries a sideband tag so downstream stage logic can re-index results. It is the streaming building block for the next-generation FFT column datapath, replacing hard-wired fixed-size column modules.

## Interface
- DATA_W, 32: signed width of each real and imaginary data component.
- TW_W, 16: signed twiddle component width, format Q1.(TW_W-1).
- TAG_W, 5: sideband tag width (point index).
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- a_re, a_im, b_re, b_im  in  DATA_W each  operands A and B.
- w_re, w_im  in  TW_W each  twiddle W.
- tag_in  in  TAG_W  sideband, passed through unchanged.
- scale  in  1  sampled with the beat; 1 = halve both results.
- out_valid  out  1  result beat valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- x_re, x_im, y_re, y_im  out  DATA_W each  results X and Y.
- tag_out  out  TAG_W  tag of the current result beat.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  synchronous clear of ovf.

## Operation
- Four register stages, each with a valid bit v[0..3]:
  - S0 registers the inputs.
  - S1 forms four products: br·wr, bi·wi, br·wi, bi·wr.
  - S2 forms p_re = br·wr − bi·wi and p_im = br·wi + bi·wr (DATA_W+TW_W+1 bits), adds 2^(TW_W-2), arithmetic-shifts right by TW_W-1, and keeps DATA_W+2 bits.
  - S3 forms X = A + P and Y = A − P at DATA_W+3 bits.
- Scaling in S3: if the beat's scale = 1, each component becomes (v+1)>>>1 (round half up) before range reduction.
- Range reduction:
  - A component overflows when its value does not fit signed DATA_W.
  - Reduction to DATA_W bits follows the Configuration section.
- Overflow flag:
  - Any overflowing component of a beat leaving S3 sets ovf.
  - ovf_clr clears ovf.
  - If set and clear occur in the same cycle, set wins.
- Flow control: a single global advance signal adv = !v[3] || out_ready.
  - All stages load only when adv = 1.
  - in_ready = adv.
  - Internal bubbles are not compressed.
- out_valid = v[3]. The output data and tag_out hold stable while out_valid && !out_ready.
- Beats leave in acceptance order. No beat is lost or duplicated.

## Timing
- Reset values: all v[] = 0, out_valid = 0, in_ready = 1, x/y/tag_out = 0, ovf = 0.
- Reset mid-operation discards all in-flight beats. The first beat can be accepted on the edge after reset deasserts.
- Latency: with no stall, a beat accepted on edge k appears with out_valid = 1 after edge k+3, i.e. 4 register stages.
- Throughput: one beat per cycle while out_ready = 1.
- in_ready depends combinationally on out_ready, which is the only combinational in-to-out path.
- Capacity under stall is 4 beats. in_ready falls in the cycle where v[3] = 1 and out_ready = 0.

## Configuration
- BFLY_SAT_EN defined:
  - Overflowing components saturate to +(2^(DATA_W-1)−1) or −2^(DATA_W-1).
- BFLY_SAT_EN undefined:
  - Components are truncated to the low DATA_W bits (two's-complement wrap).
  - Saturation logic is absent.
- ovf detection is identical in both configurations.

## Test plan
All scenarios use DATA_W=16 and TW_W=16.
- Real twiddle: A=(100,0), B=(50,0), W=(0x7FFF,0), scale=0 -> X=(150,0), Y=(50,0), ovf=0, out_valid 4 cycles after accept. Same beat with scale=1 -> X=(75,0), Y=(25,0).
- −j twiddle: A=(0,0), B=(1000,0), W=(0,−32768) -> X=(0,−1000), Y=(0,1000), tag_in=17 returned as tag_out=17.
- Overflow: A=(32767,0), B=(32767,0), W=(0x7FFF,0), scale=0:
  - With BFLY_SAT_EN -> X=(32767,0), Y=(1,0).
  - Without BFLY_SAT_EN -> X=(−3,0), Y=(1,0).
  - ovf=1 in both builds.
  - Same beat with scale=1 -> X=(32767,0), ovf stays 0.
- Sticky flag: after an overflow beat, ovf stays 1 across 10 clean beats. ovf_clr pulsed alone -> 0. ovf_clr coincident with a new overflow -> remains 1.
- Backpressure: out_ready=0, stream 6 beats with tags 0..5 -> exactly 4 accepted, in_ready=0. Outputs hold tag 0 stable. Release out_ready -> tags 0..5 emerge in order, none missing or duplicated.
- Reset mid-stream: 3 beats in flight, reset for 1 cycle -> out_valid=0, outputs zero, ovf=0. The next accepted beat emerges alone after 4 cycles.
